// File: rtl/arbiter_pkg.sv
// arbiter_pkg: shared FSM state type, requester limit and one-hot helper for mem_bus_arbiter.
package arbiter_pkg;
  typedef enum logic {IDLE, ACCESS} arb_state_t;
  localparam int ARB_MAX_REQ = 8;
  function automatic logic [ARB_MAX_REQ-1:0] onehot(input int unsigned idx, input int unsigned n);
    return (ARB_MAX_REQ'(1) << idx) & ~(ARB_MAX_REQ'('1) << n);
  endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin priority encoder, scanning from last+1 (mod NREQ).
module rr_picker #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic                    valid,
  output logic [$clog2(NREQ)-1:0] winner
);
  localparam int IW = $clog2(NREQ);
  int j;
  always_comb begin
    winner = '0;
    j = 0;
    // Walk from the farthest offset down so the nearest set request after last wins.
    for (int i = NREQ; i >= 1; i--) begin
      j = (int'(last) + i) % NREQ;
      if (req[j]) winner = IW'(j);
    end
  end
  assign valid = |req;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter sharing one RAM port between NREQ cache requesters, with lock.
// Optional ARB_PERF_CNT_EN adds saturating per-requester completed-word counters on perf_grants.
module mem_bus_arbiter
  import arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   wen,
  input  logic [NREQ-1:0]   lock,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic [DW-1:0]     rdata,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [AW-1:0]     ram_addr,
  output logic [DW-1:0]     ram_store,
  input  logic [DW-1:0]     ram_load,
  input  logic              ram_ready,
  output logic [NREQ*32-1:0] perf_grants
);
  localparam int IW = $clog2(NREQ);
  arb_state_t state, next_state;
  logic [IW-1:0] owner, next_owner, last, next_last, winner;
  logic valid, access, live, done;
  rr_picker #(.NREQ(NREQ)) u_pick (
    .req(req),
    .last(last),
    .valid(valid),
    .winner(winner)
  );
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      owner <= '0;
      last  <= IW'(NREQ - 1);
    end else begin
      state <= next_state;
      owner <= next_owner;
      last  <= next_last;
    end
  end
  assign access = state == ACCESS;
  assign live   = access && req[owner];
  assign done   = live && ram_ready;
  always_comb begin
    next_state = state;
    next_owner = owner;
    next_last  = last;
    if (!access) begin
      next_state = valid ? ACCESS : IDLE;
      next_owner = valid ? winner : owner;
    end else if (!live || (ram_ready && !lock[owner])) begin
      // Abort or final unlocked word: release the bus and rotate priority past this owner.
      next_state = IDLE;
      next_last  = owner;
    end
  end
  assign gnt       = access ? NREQ'(onehot(int'(owner), NREQ)) : '0;
  assign ack       = done ? gnt : '0;
  assign ram_wen   = live && wen[owner];
  assign ram_ren   = live && !wen[owner];
  assign ram_addr  = access ? addr[int'(owner)*AW +: AW] : '0;
  assign ram_store = access ? wdata[int'(owner)*DW +: DW] : '0;
  assign rdata     = ram_load;
`ifdef ARB_PERF_CNT_EN
  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    logic [31:0] cnt;
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) cnt <= '0;
      else if (ack[g] && cnt != 32'hFFFF_FFFF) cnt <= cnt + 32'd1;
    end
    assign perf_grants[g*32 +: 32] = cnt;
  end
`else
  assign perf_grants = '0;
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed self-checking bench for mem_bus_arbiter (NREQ=4, AW=DW=32).
module tb_mem_bus_arbiter;
  localparam int NREQ = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  logic CLK = 0;
  logic nRST;
  logic [NREQ-1:0] req, wen, lock, gnt, ack;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [DW-1:0] rdata, ram_store, ram_load;
  logic [AW-1:0] ram_addr;
  logic ram_ren, ram_wen, ram_ready;
  logic [NREQ*32-1:0] perf_grants;
  int n_cmp = 0;
  int n_err = 0;
  logic [NREQ-1:0] exp_ack;
  int order [5] = '{0, 1, 2, 3, 0};
  mem_bus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .nRST(nRST), .req(req), .wen(wen), .lock(lock), .addr(addr), .wdata(wdata),
    .gnt(gnt), .ack(ack), .rdata(rdata), .ram_ren(ram_ren), .ram_wen(ram_wen),
    .ram_addr(ram_addr), .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready),
    .perf_grants(perf_grants)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  initial begin
    nRST = 0; req = '0; wen = '0; lock = '0; addr = '0; wdata = '0;
    ram_load = '0; ram_ready = 0;
    tick(); tick();
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_en", {ram_ren, ram_wen}, 2'b00);
    chk("rst_addr", ram_addr, 32'h0);
    chk("rst_store", ram_store, 32'h0);
    chk("rst_perf", perf_grants, 128'h0);
    nRST = 1;
    // single read by requester 1
    req = 4'b0010; addr[1*AW +: AW] = 32'h0000_0040;
    #1 chk("rd_c0_gnt", gnt, 4'b0000);
    tick();
    chk("rd_c1_gnt", gnt, 4'b0010);
    chk("rd_c1_ren", ram_ren, 1'b1);
    chk("rd_c1_wen", ram_wen, 1'b0);
    chk("rd_c1_addr", ram_addr, 32'h40);
    chk("rd_c1_ack", ack, 4'b0000);
    tick();
    chk("rd_c2_ack", ack, 4'b0000);
    tick();
    ram_ready = 1; ram_load = 32'hDEAD_BEEF;
    #1 chk("rd_c3_ack", ack, 4'b0010);
    chk("rd_c3_rdata", rdata, 32'hDEAD_BEEF);
    req = '0; ram_ready = 0;
    tick();
    chk("rd_c4_gnt", gnt, 4'b0000);
    chk("rd_c4_ren", ram_ren, 1'b0);
    // round robin from a fresh reset
    nRST = 0; #1 nRST = 1;
    req = 4'b1111; ram_ready = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("rr%0d_gnt", k), gnt, 4'b1 << order[k]);
      chk($sformatf("rr%0d_ack", k), ack, 4'b1 << order[k]);
      tick();
      chk($sformatf("rr%0d_bubble_gnt", k), gnt, 4'b0000);
      chk($sformatf("rr%0d_bubble_ack", k), ack, 4'b0000);
      if (k == 3) begin
`ifdef ARB_PERF_CNT_EN
        chk("rr_perf4", perf_grants, {32'd1, 32'd1, 32'd1, 32'd1});
`else
        chk("rr_perf4", perf_grants, 128'h0);
`endif
      end
    end
    // locked two-word write by requester 3 while requester 0 waits (last=0 now)
    req = 4'b1001; wen = 4'b1000; lock = 4'b1000; ram_ready = 0;
    addr[3*AW +: AW] = 32'h100; wdata[3*DW +: DW] = 32'h11;
    tick();
    chk("lk_w0_gnt", gnt, 4'b1000);
    chk("lk_w0_en", {ram_ren, ram_wen}, 2'b01);
    chk("lk_w0_addr", ram_addr, 32'h100);
    chk("lk_w0_store", ram_store, 32'h11);
    chk("lk_w0_noack", ack, 4'b0000);
    ram_ready = 1;
    #1 chk("lk_w0_ack", ack, 4'b1000);
    tick();
    addr[3*AW +: AW] = 32'h104; wdata[3*DW +: DW] = 32'h22; lock = 4'b0000;
    #1 chk("lk_w1_gnt", gnt, 4'b1000);
    chk("lk_w1_ack", ack, 4'b1000);
    chk("lk_w1_addr", ram_addr, 32'h104);
    chk("lk_w1_store", ram_store, 32'h22);
    tick();
    chk("lk_idle_gnt", gnt, 4'b0000);
    req = 4'b0001; wen = 4'b0000;
    tick();
    chk("lk_r0_gnt", gnt, 4'b0001);
    chk("lk_r0_ack", ack, 4'b0001);
    req = '0; ram_ready = 0;
    tick();
    // abort by requester 2, then 3 must beat 0
    req = 4'b0100;
    tick();
    chk("ab_gnt", gnt, 4'b0100);
    chk("ab_ren", ram_ren, 1'b1);
    req = 4'b0000; ram_ready = 1;
    #1 chk("ab_noack", ack, 4'b0000);
    chk("ab_ren_off", ram_ren, 1'b0);
    tick();
    chk("ab_idle_gnt", gnt, 4'b0000);
    chk("ab_idle_ack", ack, 4'b0000);
    req = 4'b1001; ram_ready = 0;
    tick();
    chk("ab_next_gnt", gnt, 4'b1000);
    req = '0;
    tick();
    // reset during an access that is completing
    req = 4'b0010;
    tick(); tick();
    chk("rs_gnt", gnt, 4'b0010);
    ram_ready = 1;
    #1 chk("rs_ack_pre", ack, 4'b0010);
    nRST = 0;
    #1 chk("rs_gnt0", gnt, 4'b0000);
    chk("rs_ack0", ack, 4'b0000);
    chk("rs_en0", {ram_ren, ram_wen}, 2'b00);
    chk("rs_addr0", ram_addr, 32'h0);
    tick();
    @(negedge CLK);
    req = 4'b1111; ram_ready = 0; nRST = 1;
    tick();
    chk("rs_first", gnt, 4'b0001);
    // locked write owner with random ram_ready
    req = 4'b0001; wen = 4'b0001; lock = 4'b0001;
    tick(); tick();
    for (int k = 0; k < 20; k++) begin
      ram_ready = 1'($urandom_range(0, 1));
      #1;
      exp_ack = ram_ready ? 4'b0001 : 4'b0000;
      chk($sformatf("ex%0d_en", k), {ram_ren, ram_wen}, 2'b01);
      chk($sformatf("ex%0d_ack", k), ack, exp_ack);
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one RAM port between NREQ cache-side requesters; default is core0 icache, core0 dcache, core1 icache, core1 dcache.
- Sits between the caches and the RAM/memory model.
- Round-robin arbitration, with an optional lock so a requester can hold the bus across multi-word block transfers.
- Registered owner and state; the RAM-side signals are a combinational mux of the owner's live request.

Parameters:
NREQ, 4, number of requesters (2..8)
AW, 32, address width
DW, 32, data word width

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
req  input  NREQ  per-requester access request, held until ack
wen  input  NREQ  1 = write, 0 = read (per requester)
lock  input  NREQ  keep ownership after the current word completes
addr  input  NREQ*AW  per-requester address, requester i at [i*AW +: AW]
wdata  input  NREQ*DW  per-requester store data, same packing
gnt  output  NREQ  one-hot current owner; 0 in IDLE
ack  output  NREQ  one-hot, 1-cycle pulse when the owner's word completes
rdata  output  DW  ram_load broadcast to all requesters, valid with ack
ram_ren  output  1  RAM read enable
ram_wen  output  1  RAM write enable
ram_addr  output  AW  RAM address
ram_store  output  DW  RAM write data
ram_load  input  DW  RAM read data
ram_ready  input  1  RAM completes the current access this cycle
perf_grants  output  NREQ*32  per-requester completed-word counters (optional feature)

Behaviour:
- One clock CLK. Reset is asynchronous, active-low (nRST).
- On reset: state = IDLE, owner = 0, last = NREQ-1 (requester 0 wins first). gnt, ack, ram_ren and ram_wen are 0; ram_addr and ram_store are 0; perf counters are 0.
- Reset mid-access drops everything immediately. No ack is issued, and the requester must re-request.
- States:
  - IDLE: if any req is set, the rr_picker selects the first set req scanning from last+1 (mod NREQ). The winner is latched as owner and the state moves to ACCESS on the next edge. No req: stay in IDLE.
  - ACCESS: gnt[owner] = 1.
    - ram_wen = req[owner] & wen[owner]; ram_ren = req[owner] & ~wen[owner]. A write takes precedence, so ren and wen are never both 1.
    - ram_addr and ram_store come from the owner's slices; rdata = ram_load at all times.
    - ram_ready & req[owner]: ack[owner] = 1 for that cycle (combinational).
      - lock[owner] = 1: stay in ACCESS with the same owner; the next word starts next cycle.
      - lock[owner] = 0: last <= owner, go to IDLE.
    - req[owner] deasserted (abort): last <= owner, go to IDLE, no ack. This holds even if ram_ready is high; the RAM output is ignored.
- Latency: req rises in cycle 0, ram enable in cycle 1, ack in the cycle ram_ready is seen. Unlocked back-to-back accesses insert one IDLE bubble.
- Fairness: an unlocked requester waits at most NREQ-1 other grants. A locked owner may starve others; requesters must bound lock length (one cache block).
- Requests arriving during ACCESS are not latched; req must be held until ack.
- ack is never issued to a non-owner. gnt and ack are always one-hot or zero.
- ram_ready while in IDLE is ignored.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined: perf_grants[i*32 +: 32] increments on every ack[i] and saturates at 32'hFFFF_FFFF. Counters reset to 0.
- Undefined: no counter registers; perf_grants is tied to 0. Port list is unchanged.

Decomposition:
- Package arbiter_pkg:
  - arb_state_t enum {IDLE, ACCESS}
  - ARB_MAX_REQ = 8
  - helper function onehot(idx, n)
- Sub-module rr_picker: combinational round-robin priority encoder.
  - Inputs: req vector, last index.
  - Outputs: valid, winner index.
- The top level holds the FSM, owner/last registers, the RAM mux and the counters.

Test Plan:
- Single read: req[1]=1, wen=0, addr[1]=0x0000_0040, ram_ready on cycle 3, ram_load=0xDEADBEEF.
  -> Cycle 1: gnt=4'b0010, ram_ren=1, ram_addr=0x40.
  -> Cycle 3: ack=4'b0010, rdata=0xDEADBEEF. Cycle 4: IDLE, gnt=0.
- Round-robin: all four req held high, ram_ready=1 in every ACCESS cycle.
  -> Grant order 0,1,2,3,0, each followed by one IDLE bubble.
  -> With ARB_PERF_CNT_EN, each counter = 1 after the first four acks.
- Locked block write: req[3]=1, wen=1, lock=1 for two words (addr 0x100 then 0x104, wdata 0x11 then 0x22), with req[0] also high.
  -> Two consecutive acks to requester 3, no IDLE between them, ram_store 0x11 then 0x22.
  -> Requester 0 granted only after lock drops.
- Abort: requester 2 granted, req[2] drops before ram_ready.
  -> Next cycle IDLE, ack=0, ram_ren=0, last=2, so requester 3 has priority over 0 next.
- Reset mid-access: nRST low during ACCESS with ram_ready high.
  -> gnt, ack, ram_ren and ram_wen go to 0 immediately with no ack pulse.
  -> After release, requester 0 wins first arbitration.
- Write/read exclusivity: owner has wen=1; sweep random ram_ready.
  -> ram_ren is never 1 while ram_wen=1; ack appears only with ram_ready.
